// File: rtl/cds_sampler.sv
// Correlated double sampler for a linear CCD: captures reset and signal levels
// after each phase edge and emits their saturating difference with line position.
module cds_sampler #(
  parameter int ADC_W        = 12,
  parameter int SETTLE       = 2,
  parameter int PIX_PER_LINE = 3648
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             phi_p,
  input  logic             phi_l2,
  input  logic             phi_r,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pixel_data,
  output logic             pixel_valid,
  output logic [11:0]      pixel_index,
  output logic             line_end,
  output logic             overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    SET_R  = 3'd2,
    WAIT_L = 3'd3,
    SET_S  = 3'd4
  } state_t;

  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [11:0] LAST_PIX  = 12'(PIX_PER_LINE - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ADC_W-1:0] rlvl_q, rlvl_d;
  logic [11:0]      pix_cnt_q, pix_cnt_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [11:0]      idx_q, idx_d;
  logic             le_q, le_d;
  logic             ovr_q, ovr_d;
  logic             phi_r_q, phi_l2_q, phi_p_q, en_q;

  logic             fall_r, fall_l2, rise_p, en_rise;
  logic             emit, ovr_set;
  logic [ADC_W-1:0] diff;

  assign fall_r  = phi_r_q & ~phi_r;
  assign fall_l2 = phi_l2_q & ~phi_l2;
  assign rise_p  = ~phi_p_q & phi_p;
  assign en_rise = enable & ~en_q;

  // A signal level above the reset level is noise/clipping, not negative light.
  assign diff = (adc_data > rlvl_q) ? '0 : (rlvl_q - adc_data);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rlvl_d  = rlvl_q;
    emit    = 1'b0;
    ovr_set = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (fall_r) begin
            state_d = SET_R;
            cnt_d   = SETTLE_LD;
          end
        end
        SET_R: begin
          if (cnt_q == 4'd0) begin
            rlvl_d  = adc_data;
            state_d = WAIT_L;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        WAIT_L: begin
          if (fall_r) begin
            ovr_set = 1'b1;
            state_d = SET_R;
            cnt_d   = SETTLE_LD;
          end else if (fall_l2) begin
            state_d = SET_S;
            cnt_d   = SETTLE_LD;
          end
        end
        SET_S: begin
          // An early reset fall wins over a pending capture: the pixel is lost.
          if (fall_r) begin
            ovr_set = 1'b1;
            state_d = SET_R;
            cnt_d   = SETTLE_LD;
          end else if (cnt_q == 4'd0) begin
            emit    = 1'b1;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = emit ? diff : data_q;
    valid_d = emit;
    idx_d   = emit ? pix_cnt_q : idx_q;
    le_d    = emit && (pix_cnt_q == LAST_PIX);
    ovr_d   = en_rise ? 1'b0 : (ovr_q | ovr_set);
    pix_cnt_d = pix_cnt_q;
    if (rise_p) begin
      pix_cnt_d = 12'd0;
    end else if (emit) begin
      pix_cnt_d = (pix_cnt_q == LAST_PIX) ? 12'd0 : (pix_cnt_q + 12'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rlvl_q    <= '0;
      pix_cnt_q <= 12'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 12'd0;
      le_q      <= 1'b0;
      ovr_q     <= 1'b0;
      phi_r_q   <= 1'b0;
      phi_l2_q  <= 1'b0;
      phi_p_q   <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rlvl_q    <= rlvl_d;
      pix_cnt_q <= pix_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      le_q      <= le_d;
      ovr_q     <= ovr_d;
      phi_r_q   <= phi_r;
      phi_l2_q  <= phi_l2;
      phi_p_q   <= phi_p;
      en_q      <= enable;
    end
  end

  assign pixel_data  = data_q;
  assign pixel_valid = valid_q;
  assign pixel_index = idx_q;
  assign line_end    = le_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_cds_sampler.sv
// Bench for cds_sampler: directed pixel scenarios plus random phase activity,
// all checked against an event-timestamp reference model.
module tb_cds_sampler;

  localparam int ADC_W  = 12;
  localparam int SETTLE = 2;
  localparam int PPL    = 4;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        enable  = 1'b0;
  logic        phi_p   = 1'b0;
  logic        phi_l2  = 1'b0;
  logic        phi_r   = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic [11:0] pixel_data;
  logic        pixel_valid;
  logic [11:0] pixel_index;
  logic        line_end;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  cds_sampler #(.ADC_W(ADC_W), .SETTLE(SETTLE), .PIX_PER_LINE(PPL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .phi_p(phi_p), .phi_l2(phi_l2),
    .phi_r(phi_r), .adc_data(adc_data), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_index(pixel_index), .line_end(line_end),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: remembers the edge number at which each capture is due.
  int          m_n, m_rst_at, m_sig_at, m_cnt;
  bit          m_active, m_have_rst, m_ovr;
  logic [11:0] m_rlvl;
  bit          p_r, p_l2, p_p, p_en;
  bit          e_valid, e_le;
  logic [11:0] e_data, e_idx;

  task automatic model_reset();
    m_rst_at = -1; m_sig_at = -1; m_cnt = 0;
    m_active = 0; m_have_rst = 0; m_ovr = 0; m_rlvl = 0;
    p_r = 0; p_l2 = 0; p_p = 0; p_en = 0;
    e_valid = 0; e_le = 0; e_data = 0; e_idx = 0;
  endtask

  task automatic model_edge();
    bit fr, fl, rp, emit;
    fr = p_r & ~phi_r;
    fl = p_l2 & ~phi_l2;
    rp = ~p_p & phi_p;
    emit = 0;
    e_valid = 0;
    e_le = 0;
    if (enable && !p_en) m_ovr = 0;
    if (!enable) begin
      m_active = 0; m_rst_at = -1; m_sig_at = -1; m_have_rst = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      if (fr && m_rst_at < 0) begin
        if (m_have_rst || m_sig_at >= 0) m_ovr = 1;
        m_rst_at = m_n + SETTLE;
        m_have_rst = 0;
        m_sig_at = -1;
      end else if (fl && m_have_rst && m_sig_at < 0) begin
        m_sig_at = m_n + SETTLE;
      end
      if (m_rst_at == m_n) begin
        m_rlvl = adc_data;
        m_have_rst = 1;
        m_rst_at = -1;
      end else if (m_sig_at == m_n) begin
        emit = 1;
        e_data = (adc_data > m_rlvl) ? 12'd0 : m_rlvl - adc_data;
        m_have_rst = 0;
        m_sig_at = -1;
      end
    end
    if (emit) begin
      e_valid = 1;
      e_idx = 12'(m_cnt);
      e_le = (m_cnt == PPL - 1);
      m_cnt = (m_cnt == PPL - 1) ? 0 : m_cnt + 1;
    end
    if (rp) m_cnt = 0;
    p_r = phi_r; p_l2 = phi_l2; p_p = phi_p; p_en = enable;
    m_n++;
  endtask

  task automatic compare_all();
    check("pixel_valid", pixel_valid, e_valid);
    check("pixel_data", pixel_data, e_data);
    check("pixel_index", pixel_index, e_idx);
    check("line_end", line_end, e_le);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic reset_phase(input logic [11:0] rl);
    phi_r = 1'b1; adc_data = rl;
    cycle(); cycle();
    phi_r = 1'b0;
    cycle();
    repeat (SETTLE) cycle();
  endtask

  task automatic signal_phase(input logic [11:0] sl, input bit p_at_emit, input int exp_idx);
    phi_l2 = 1'b1; adc_data = sl;
    cycle(); cycle();
    phi_l2 = 1'b0;
    cycle();
    repeat (SETTLE - 1) begin
      cycle();
      check("lat_pre", pixel_valid, 1'b0);
    end
    if (p_at_emit) phi_p = 1'b1;
    cycle();
    check("lat_emit", pixel_valid, 1'b1);
    check("emit_idx", pixel_index, 32'(exp_idx));
    check("emit_le", line_end, (exp_idx == PPL - 1) ? 1'b1 : 1'b0);
    cycle();
    check("strobe_1cyc", pixel_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0; enable = 1'b1;
    cycle(); cycle();

    reset_phase(12'h800); signal_phase(12'h300, 0, 0);
    check("cds_500", pixel_data, 12'h500);
    reset_phase(12'h100); signal_phase(12'h200, 0, 1);
    check("saturate", pixel_data, 12'h000);
    reset_phase(12'h0a0); signal_phase(12'h020, 0, 2);
    reset_phase(12'hfff); signal_phase(12'h000, 0, 3);
    check("full_scale", pixel_data, 12'hfff);
    reset_phase(12'h400); signal_phase(12'h123, 0, 0);
    repeat (3) begin
      cycle();
      check("hold_data", pixel_data, 12'h2dd);
    end

    reset_phase(12'h300); signal_phase(12'h100, 0, 1);
    reset_phase(12'h300); signal_phase(12'h100, 1, 2);
    phi_p = 1'b0;
    reset_phase(12'h300); signal_phase(12'h100, 0, 0);

    reset_phase(12'h700);
    phi_r = 1'b1; cycle();
    phi_r = 1'b0; cycle();
    check("ovr_set", overrun, 1'b1);
    check("ovr_no_pix", pixel_valid, 1'b0);
    repeat (SETTLE) cycle();
    signal_phase(12'h200, 0, 1);
    check("ovr_pix", pixel_data, 12'h500);
    check("ovr_sticky", overrun, 1'b1);
    enable = 1'b0; cycle();
    check("ovr_hold_dis", overrun, 1'b1);
    enable = 1'b1; cycle();
    check("ovr_clear", overrun, 1'b0);
    cycle();

    reset_phase(12'h900);
    phi_l2 = 1'b1; adc_data = 12'h100;
    cycle(); cycle();
    phi_l2 = 1'b0; cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_async_data", pixel_data, 12'h000);
    repeat (2) cycle();
    rst = 1'b0;
    phi_l2 = 1'b1; cycle(); cycle();
    phi_l2 = 1'b0;
    repeat (SETTLE + 3) begin
      cycle();
      check("rst_no_pix", pixel_valid, 1'b0);
    end
    reset_phase(12'h600); signal_phase(12'h200, 0, 0);
    check("post_rst_pix", pixel_data, 12'h400);

    repeat (3000) begin
      if ($urandom_range(5) == 0) phi_r = ~phi_r;
      if ($urandom_range(4) == 0) phi_l2 = ~phi_l2;
      if ($urandom_range(39) == 0) phi_p = ~phi_p;
      enable = ($urandom_range(149) != 0);
      adc_data = 12'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
